smplfifo_drain_arb: RTL

Round-robin drain scheduler for a bank of NCH sample FIFOs (one per microphone channel). It pops words from one granted FIFO at a time, in bursts of bounded length. Popped words go to a single registered valid/ready output stream tagged with the channel number. It sits between the per-channel FIFOs and the Wishbone/DMA packer.

---
 rtl/smplfifo_drain_pkg.sv | 17 +
 rtl/smplfifo_drain_arb_rr_pick.sv | 51 +++++
 rtl/smplfifo_drain_arb.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/smplfifo_drain_pkg.sv
// smplfifo_drain_pkg
//   Shared types and helpers for the sample-FIFO drain arbiter.
//   - drain_state_e : arbiter FSM states (ARB searches, XFER drains one channel)
//   - chan_width()  : width of a channel index for a given channel count
package smplfifo_drain_pkg;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } drain_state_e;

    // A single channel still needs a one-bit tag so ports never collapse to zero width.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/smplfifo_drain_arb_rr_pick.sv
// rr_pick
//   Combinational rotating-priority encoder. Returns the first asserted
//   request at or after the start pointer, wrapping modulo NCH.
// Ports:
//   req   in  NCH  request vector
//   start in  CW   channel with highest priority (must be < NCH)
//   found out 1    at least one request is asserted
//   idx   out CW   index of the winning request (0 when none)
module rr_pick
    import smplfifo_drain_pkg::*;
#(
    parameter int  NCH = 4,
    localparam int CW  = chan_width(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  start,
    output logic           found,
    output logic [CW-1:0]  idx
);

    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    int               off;
    int               sum;

    // Rotate the request vector so bit k of rot is channel (start+k) mod NCH.
    assign dbl = {req, req};
    assign rot = dbl[NCH-1:0] == '0 ? '0 : NCH'(dbl >> start);

    always_comb begin
        found = 1'b0;
        off   = 0;
        sum   = 0;
        idx   = '0;
        // Descending scan so the lowest rotated offset is the last to write.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = int'(start) + off;
        if (sum >= NCH) begin
            sum = sum - NCH;
        end
        if (found) begin
            idx = CW'(sum);
        end
    end

endmodule

// File: rtl/smplfifo_drain_arb.sv
// smplfifo_drain_arb
//   Round-robin drain scheduler for NCH sample FIFOs. One channel is granted
//   at a time and drained for up to i_burst+1 words; each popped word goes to
//   a registered output stream tagged with its channel.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_en      [NCH]     per-channel enable mask
//   i_burst   [LGBURST] burst length minus one, captured at grant
//   i_empty_n [NCH]     per-FIFO non-empty flag
//   i_data    [NCH*BW]  per-FIFO head word, channel c at [c*BW +: BW]
//   o_rd      [NCH]     per-FIFO pop strobe (combinational, one-hot or zero)
//   o_valid, i_ready    output stream handshake
//   o_data    [BW]      output sample
//   o_chan    [CW]      source channel of o_data
//   o_first             word is the first of its grant
//   o_busy              a grant is active (FSM in XFER)
//
// Handshake: a word transfers on any rising edge where o_valid && i_ready.
// While o_valid && !i_ready the word, channel and first flag are held
// stable and no pop is issued. A new word can be loaded on the same edge
// the previous one is accepted, so each o_rd pulse yields exactly one
// transfer.
module smplfifo_drain_arb
    import smplfifo_drain_pkg::*;
#(
    parameter int  NCH     = 4,
    parameter int  BW      = 12,
    parameter int  LGBURST = 3,
    localparam int CW      = chan_width(NCH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NCH-1:0]       i_en,
    input  logic [LGBURST-1:0]   i_burst,
    input  logic [NCH-1:0]       i_empty_n,
    input  logic [NCH*BW-1:0]    i_data,
    output logic [NCH-1:0]       o_rd,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [BW-1:0]        o_data,
    output logic [CW-1:0]        o_chan,
    output logic                 o_first,
    output logic                 o_busy
);

    localparam int            CNTW    = LGBURST + 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    drain_state_e       state_q;
    drain_state_e       state_d;
    logic [CW-1:0]      r_ptr;
    logic [CW-1:0]      grant;
    logic [CNTW-1:0]    count;
    logic [LGBURST-1:0] len;
    logic               first;

    logic [NCH-1:0]     req;
    logic               pick_found;
    logic [CW-1:0]      pick_idx;
    logic [BW-1:0]      head [NCH];
    logic               grant_elig;
    logic               pop;
    logic               burst_done;

    assign req = i_en & i_empty_n;

    rr_pick #(
        .NCH   (NCH)
    ) u_pick (
        .req   (req),
        .start (r_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_head
        assign head[g] = i_data[g*BW +: BW];
    end

    // Enable and empty are looked at in the same cycle, so dropping i_en
    // blocks the very next pop.
    assign grant_elig = i_en[grant] && i_empty_n[grant];
    assign pop        = (state_q == ST_XFER) && grant_elig && (!o_valid || i_ready);
    // Count is one bit wider than len so len at its maximum still terminates.
    assign burst_done = (state_q == ST_XFER) &&
                        (pop ? (count == {1'b0, len}) : !grant_elig);
    assign o_busy     = (state_q == ST_XFER);

    always_comb begin
        o_rd = '0;
        if (pop) begin
            o_rd[grant] = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:  if (pick_found) state_d = ST_XFER;
            ST_XFER: if (burst_done) state_d = ST_ARB;
            default: state_d = ST_ARB;
        endcase
    end

    // Grant, burst counter and round-robin pointer
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
            grant <= '0;
            count <= '0;
            len   <= '0;
            first <= 1'b0;
        end else begin
            if (state_q == ST_ARB && pick_found) begin
                grant <= pick_idx;
                count <= '0;
                len   <= i_burst;
                first <= 1'b1;
            end
            if (pop) begin
                first <= 1'b0;
                count <= count + CNTW'(1);
            end
            // Next search starts just past the channel that was served.
            if (burst_done) begin
                r_ptr <= (grant == LAST_CH) ? '0 : grant + CW'(1);
            end
        end
    end

    // Output register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_chan  <= '0;
            o_first <= 1'b0;
        end else if (pop) begin
            o_valid <= 1'b1;
            o_data  <= head[grant];
            o_chan  <= grant;
            o_first <= first;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
